// File: rtl/regfile_pkg.sv
// Shared register-file constants for decode and writeback.
// Defaults match the RV32I core: 32 x 32-bit registers, x0 hardwired to zero.
package regfile_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);
  localparam int ZERO_REG  = 0;
  localparam int NRD_DEF   = 2;
  localparam int NWR_DEF   = 1;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set at issue, cleared at writeback, set wins on a clash.
// Latency: one cycle to update. No backpressure; the bits are always current.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NWR   = NWR_DEF,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sb_set,
  input  logic [AW-1:0]     i_sb_addr,
  input  logic [NWR-1:0]    i_wr_en,
  input  logic [NWR*AW-1:0] i_wr_addr,
  output logic [NREGS-1:0]  o_busy
);
  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;

  // Clears first, then the set, so a younger issue keeps its claim.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int j = 0; j < NWR; j++) begin
      if (i_wr_en[j]) w_busy_nxt[i_wr_addr[j*AW +: AW]] = 1'b0;
    end
    if (i_sb_set) w_busy_nxt[i_sb_addr] = 1'b1;
    w_busy_nxt[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_busy <= '0;
    else       r_busy <= w_busy_nxt;
  end

  assign o_busy = r_busy;
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with optional write-to-read bypass and busy scoreboard.
// Latency: reads combinational, writes visible next cycle. No backpressure.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = NRD_DEF,
  parameter int NWR    = NWR_DEF,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NRD*AW-1:0]   i_rd_addr,
  output logic [NRD*XLEN-1:0] o_rd_data,
  output logic [NRD-1:0]      o_rd_busy,
  input  logic [NWR-1:0]      i_wr_en,
  input  logic [NWR*AW-1:0]   i_wr_addr,
  input  logic [NWR*XLEN-1:0] i_wr_data,
  input  logic                i_sb_set,
  input  logic [AW-1:0]       i_sb_addr
);
  logic [XLEN-1:0]  r_mem [NREGS];
  logic [NREGS-1:0] w_busy;
  logic [AW-1:0]    w_ra;
  logic [XLEN-1:0]  w_rdat;
  logic             w_rbusy;

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR)
  ) u_sb (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_sb_set  (i_sb_set),
    .i_sb_addr (i_sb_addr),
    .i_wr_en   (i_wr_en),
    .i_wr_addr (i_wr_addr),
    .o_busy    (w_busy)
  );

  // Higher write port is applied last so it wins a same-address collision.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < NREGS; k++) r_mem[k] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (i_wr_en[j] && (i_wr_addr[j*AW +: AW] != AW'(ZERO_REG)))
          r_mem[i_wr_addr[j*AW +: AW]] <= i_wr_data[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    o_rd_data = '0;
    o_rd_busy = '0;
    w_ra      = '0;
    w_rdat    = '0;
    w_rbusy   = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      w_ra    = i_rd_addr[i*AW +: AW];
      w_rdat  = r_mem[w_ra];
      w_rbusy = w_busy[w_ra];
      if (BYPASS != 0) begin
        for (int j = 0; j < NWR; j++) begin
          if (i_wr_en[j] && (i_wr_addr[j*AW +: AW] == w_ra)) begin
            w_rdat = i_wr_data[j*XLEN +: XLEN];
            // A same-cycle issue to this register re-claims it past the writeback.
            if (!(i_sb_set && (i_sb_addr == w_ra))) w_rbusy = 1'b0;
          end
        end
      end
      if (w_ra == AW'(ZERO_REG)) begin
        w_rdat  = '0;
        w_rbusy = 1'b0;
      end
      o_rd_data[i*XLEN +: XLEN] = w_rdat;
      o_rd_busy[i]              = w_rbusy;
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: two dual-write instances (bypass on/off) share stimulus; a cycle table
// covers x0, bypass, collisions and scoreboard, then hand sequences for reset and a full sweep.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int AW = 5;
  localparam int NRD = 2;
  localparam int NWR = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data_b, rd_data_n;
  logic [NRD-1:0]      rd_busy_b, rd_busy_n;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                sb_set;
  logic [AW-1:0]       sb_addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)) u_byp (
    .i_clk(clk), .i_rst(rst), .i_rd_addr(rd_addr), .o_rd_data(rd_data_b), .o_rd_busy(rd_busy_b),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_sb_set(sb_set), .i_sb_addr(sb_addr)
  );

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)) u_nb (
    .i_clk(clk), .i_rst(rst), .i_rd_addr(rd_addr), .o_rd_data(rd_data_n), .o_rd_busy(rd_busy_n),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_sb_set(sb_set), .i_sb_addr(sb_addr)
  );

  typedef struct {
    string       name;
    logic [1:0]  wen;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        sbs;
    logic [4:0]  sba, ra0, ra1;
    logic [31:0] bd0, bd1;
    logic [1:0]  bbz;
    logic [31:0] nd0, nd1;
    logic [1:0]  nbz;
  } vec_t;

  vec_t vecs[17];

  task automatic drive(input logic [1:0] wen, input logic [4:0] wa0, input logic [4:0] wa1,
                       input logic [31:0] wd0, input logic [31:0] wd1, input logic sbs,
                       input logic [4:0] sba, input logic [4:0] ra0, input logic [4:0] ra1);
    wr_en   = wen;
    wr_addr = {wa1, wa0};
    wr_data = {wd1, wd0};
    sb_set  = sbs;
    sb_addr = sba;
    rd_addr = {ra1, ra0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_both(input string name, input logic [31:0] bd0, input logic [31:0] bd1,
                          input logic [1:0] bbz, input logic [31:0] nd0, input logic [31:0] nd1,
                          input logic [1:0] nbz);
    chk({name, ".byp.d0"}, rd_data_b[31:0],  bd0);
    chk({name, ".byp.d1"}, rd_data_b[63:32], bd1);
    chk({name, ".byp.bz"}, {30'd0, rd_busy_b}, {30'd0, bbz});
    chk({name, ".nb.d0"},  rd_data_n[31:0],  nd0);
    chk({name, ".nb.d1"},  rd_data_n[63:32], nd1);
    chk({name, ".nb.bz"},  {30'd0, rd_busy_n}, {30'd0, nbz});
  endtask

  initial begin
    //           name        wen    wa0 wa1 wd0            wd1          sbs sba ra0 ra1 byp d0/d1/bz                   nb d0/d1/bz
    vecs[0]  = '{"x0_wr",    2'b01, 0,  0,  32'hFFFFFFFF, 32'h0,       1, 0,  0,  0,  32'h0,    32'h0,        2'b00, 32'h0,    32'h0,        2'b00};
    vecs[1]  = '{"x0_next",  2'b00, 0,  0,  32'h0,        32'h0,       0, 0,  0,  0,  32'h0,    32'h0,        2'b00, 32'h0,    32'h0,        2'b00};
    vecs[2]  = '{"byp_x7",   2'b01, 7,  0,  32'h12345678, 32'h0,       0, 0,  0,  7,  32'h0,    32'h12345678, 2'b00, 32'h0,    32'h0,        2'b00};
    vecs[3]  = '{"x7_next",  2'b00, 0,  0,  32'h0,        32'h0,       0, 0,  0,  7,  32'h0,    32'h12345678, 2'b00, 32'h0,    32'h12345678, 2'b00};
    vecs[4]  = '{"coll_x9",  2'b11, 9,  9,  32'h1111,     32'h2222,    0, 0,  9,  7,  32'h2222, 32'h12345678, 2'b00, 32'h0,    32'h12345678, 2'b00};
    vecs[5]  = '{"x9_next",  2'b00, 0,  0,  32'h0,        32'h0,       0, 0,  9,  7,  32'h2222, 32'h12345678, 2'b00, 32'h2222, 32'h12345678, 2'b00};
    vecs[6]  = '{"sb_x3",    2'b00, 0,  0,  32'h0,        32'h0,       1, 3,  3,  0,  32'h0,    32'h0,        2'b00, 32'h0,    32'h0,        2'b00};
    vecs[7]  = '{"x3_busy",  2'b00, 0,  0,  32'h0,        32'h0,       0, 0,  3,  0,  32'h0,    32'h0,        2'b01, 32'h0,    32'h0,        2'b01};
    vecs[8]  = '{"wr_sb_x3", 2'b01, 3,  0,  32'h33,       32'h0,       1, 3,  3,  0,  32'h33,   32'h0,        2'b01, 32'h0,    32'h0,        2'b01};
    vecs[9]  = '{"x3_still", 2'b00, 0,  0,  32'h0,        32'h0,       0, 0,  3,  0,  32'h33,   32'h0,        2'b01, 32'h33,   32'h0,        2'b01};
    vecs[10] = '{"wr_x3",    2'b01, 3,  0,  32'h44,       32'h0,       0, 0,  3,  0,  32'h44,   32'h0,        2'b00, 32'h33,   32'h0,        2'b01};
    vecs[11] = '{"x3_clr",   2'b00, 0,  0,  32'h0,        32'h0,       0, 0,  3,  0,  32'h44,   32'h0,        2'b00, 32'h44,   32'h0,        2'b00};
    vecs[12] = '{"sb_x4",    2'b00, 0,  0,  32'h0,        32'h0,       1, 4,  0,  4,  32'h0,    32'h0,        2'b00, 32'h0,    32'h0,        2'b00};
    vecs[13] = '{"coll_x4",  2'b11, 4,  4,  32'h66,       32'h55,      0, 0,  0,  4,  32'h0,    32'h55,       2'b00, 32'h0,    32'h0,        2'b10};
    vecs[14] = '{"x4_clr",   2'b00, 0,  0,  32'h0,        32'h0,       0, 0,  0,  4,  32'h0,    32'h55,       2'b00, 32'h0,    32'h55,       2'b00};
    vecs[15] = '{"noen_x5",  2'b00, 5,  5,  32'hBAD,      32'hBAD,     0, 0,  5,  5,  32'h0,    32'h0,        2'b00, 32'h0,    32'h0,        2'b00};
    vecs[16] = '{"x5_next",  2'b00, 0,  0,  32'h0,        32'h0,       0, 0,  5,  5,  32'h0,    32'h0,        2'b00, 32'h0,    32'h0,        2'b00};

    rst = 1'b1;
    drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;

    drive(2'b00, 0, 0, 0, 0, 0, 0, 5, 31);
    #1;
    chk_both("rst_init", 32'h0, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00);
    tick();

    for (int v = 0; v < 17; v++) begin
      drive(vecs[v].wen, vecs[v].wa0, vecs[v].wa1, vecs[v].wd0, vecs[v].wd1,
            vecs[v].sbs, vecs[v].sba, vecs[v].ra0, vecs[v].ra1);
      #1;
      chk_both(vecs[v].name, vecs[v].bd0, vecs[v].bd1, vecs[v].bbz,
               vecs[v].nd0, vecs[v].nd1, vecs[v].nbz);
      tick();
    end

    // Reset clear: populate x5 and busy x6, then reset with a write/issue that must be dropped.
    drive(2'b01, 5, 0, 32'hDEADBEEF, 0, 1, 6, 0, 0);
    tick();
    drive(2'b00, 0, 0, 0, 0, 0, 0, 5, 6);
    #1;
    chk_both("pre_rst", 32'hDEADBEEF, 32'h0, 2'b10, 32'hDEADBEEF, 32'h0, 2'b10);
    tick();
    rst = 1'b1;
    drive(2'b10, 0, 8, 0, 32'h88, 1, 8, 5, 6);
    tick();
    rst = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      drive(2'b00, 0, 0, 0, 0, 0, 0, 5'(r), 5'(NREGS - 1 - r));
      #1;
      chk_both($sformatf("post_rst_x%0d", r), 32'h0, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00);
      tick();
    end

    // Back-to-back: write x_i while issuing x_(i+1); each busy bit is cleared a cycle after it is set.
    for (int i = 0; i < NREGS; i++) begin
      drive(2'b01, 5'(i), 0, 32'hA0000000 + 32'(i), 0, 1, 5'((i + 1) % NREGS), 5'(i), 5'(i));
      #1;
      chk($sformatf("b2b_byp_x%0d", i), rd_data_b[63:32], (i == 0) ? 32'h0 : 32'hA0000000 + 32'(i));
      chk($sformatf("b2b_byp_bz_x%0d", i), {31'd0, rd_busy_b[1]}, 32'h0);
      chk($sformatf("b2b_nb_bz_x%0d", i), {31'd0, rd_busy_n[1]}, (i == 0) ? 32'h0 : 32'h1);
      tick();
    end
    for (int r = 0; r < NREGS; r++) begin
      drive(2'b00, 0, 0, 0, 0, 0, 0, 5'(r), 5'(r));
      #1;
      chk_both($sformatf("b2b_rd_x%0d", r),
               (r == 0) ? 32'h0 : 32'hA0000000 + 32'(r), (r == 0) ? 32'h0 : 32'hA0000000 + 32'(r), 2'b00,
               (r == 0) ? 32'h0 : 32'hA0000000 + 32'(r), (r == 0) ? 32'h0 : 32'hA0000000 + 32'(r), 2'b00);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
